// File: rtl/otter_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : otter_mux_pkg
//  Purpose  : Shared constants and helpers for the arbitrated output mux.
//             ARB_FIXED / ARB_RR select the arbitration mode, and
//             clog2_min1() gives a channel index width that is at least 1 bit.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package otter_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A single channel still needs a 1-bit index so every port keeps a legal width.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_mux_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Purely combinational N-way arbiter. It picks one requester by
//             fixed priority, by round-robin from a start pointer, or by a
//             forced select.
//  Ports    : req       - per-channel request
//             ptr       - round-robin start index (ignored in fixed mode)
//             force_en  - bypass arbitration and use force_sel
//             force_sel - forced channel index
//             gnt_valid - a channel is granted
//             gnt_idx   - granted channel index
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import otter_mux_pkg::*;
#(
  parameter int N   = 4,
  parameter int RR  = ARB_RR,
  parameter int CHW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic [CHW-1:0] ptr,
  input  logic           force_en,
  input  logic [CHW-1:0] force_sel,
  output logic           gnt_valid,
  output logic [CHW-1:0] gnt_idx
);

  logic [CHW-1:0] start_ptr;
  logic [N-1:0]   hi_mask;
  logic [N-1:0]   masked_req;

  // Fixed priority is a round-robin search that always starts at channel 0.
  assign start_ptr = (RR == ARB_FIXED) ? '0 : ptr;

  // Requests at or above the start pointer are tried first. If none of them
  // is active, the lowest active request wraps the search round to index 0.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (CHW'(i) >= start_ptr);
    end
  end

  assign masked_req = req & hi_mask;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (force_en) begin
      // An out-of-range force_sel matches no channel, so it gives no grant.
      for (int i = 0; i < N; i++) begin
        if (force_sel == CHW'(i) && req[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = CHW'(i);
        end
      end
    end else if (|masked_req) begin
      // Scan downwards so that the lowest set bit is the last one written.
      gnt_valid = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (masked_req[i]) gnt_idx = CHW'(i);
      end
    end else if (|req) begin
      gnt_valid = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) gnt_idx = CHW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_mux_reg
//  Purpose  : N-to-1 arbitrated data selector with valid/ready handshakes on
//             every input and a registered output stage.
//  Ports    : CLK       - clock, rising edge
//             RST_N     - asynchronous active-low reset
//             in_data   - packed channel data, channel i at [i*WIDTH +: WIDTH]
//             in_valid  - per-channel valid
//             in_ready  - per-channel ready (combinational, at most one set)
//             force_en  - bypass arbitration and use force_sel
//             force_sel - forced channel index
//             out_data  - registered selected data
//             out_chan  - registered source channel of out_data
//             out_valid - registered output valid
//             out_ready - sink ready
//  Revision : 1.0 - initial release
// ============================================================================
module arb_mux_reg
  import otter_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int RR    = ARB_RR
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [N*WIDTH-1:0]          in_data,
  input  logic [N-1:0]                in_valid,
  output logic [N-1:0]                in_ready,
  input  logic                        force_en,
  input  logic [clog2_min1(N)-1:0]    force_sel,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2_min1(N)-1:0]    out_chan,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int CHW = clog2_min1(N);

  logic [CHW-1:0]   rr_ptr;
  logic             load;
  logic             gnt_valid;
  logic [CHW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_data;

  // The output register takes a word when it is empty or is being drained
  // in this cycle. This gives full throughput while out_ready stays high.
  assign load = !out_valid || out_ready;

  rr_arbiter #(
    .N   (N),
    .RR  (RR),
    .CHW (CHW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .force_en  (force_en),
    .force_sel (force_sel),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  generate
    for (genvar g = 0; g < N; g++) begin : g_ready
      assign in_ready[g] = load && gnt_valid && (gnt_idx == CHW'(g));
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == CHW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (gnt_valid) begin
        out_data  <= sel_data;
        out_chan  <= gnt_idx;
        out_valid <= 1'b1;
        // A forced transfer does not advance the pointer. This keeps the
        // round-robin order fair after the force is released.
        if (RR == ARB_RR && !force_en) begin
          rr_ptr <= (gnt_idx == CHW'(N - 1)) ? '0 : gnt_idx + CHW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
